// File: rtl/frida_pkg.sv
// Shared types and constants for the FRIDA SPI configuration slave.
// Build option: SPI_READBACK_EN (see frida_spi_cfg.sv).
package frida_pkg;

    localparam int CFG_W_DEF = 180;
    localparam int CNT_W     = $clog2(CFG_W_DEF + 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_t;

endpackage

// File: rtl/frida_sync.sv
// Multi-flop bit synchronizer with selectable reset value.
// Build option: none.
module frida_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff <= {STAGES{RST_VAL}};
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/frida_spi_cfg.sv
// Oversampling SPI slave that commits whole CFG_W-bit frames to cfg_q.
// Build option: SPI_READBACK_EN shifts the previous cfg_q out on spi_sdo.
module frida_spi_cfg
    import frida_pkg::*;
#(
    parameter int CFG_W       = CFG_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_sdi,
    input  logic             spi_cs_b,
    output logic             spi_sdo,
    output logic [CFG_W-1:0] cfg_q,
    output logic             cfg_valid,
    output logic             cfg_update,
    output logic             frame_err
);

    localparam int            CW       = $clog2(CFG_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_W + 1);

    logic w_sclk_s;
    logic w_sdi_s;
    logic w_cs_s;
    logic w_sclk_rise;
    logic w_cs_rise;
    logic [CFG_W-1:0] w_preload;

    logic             r_sclk_d;
    logic             r_cs_d;
    spi_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [CFG_W-1:0] r_sreg;
    logic [CFG_W-1:0] r_cfg;
    logic             r_valid;
    logic             r_update;
    logic             r_err;

    frida_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .i_d (spi_sclk),
        .o_q (w_sclk_s)
    );

    frida_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk (clk),
        .rst (rst),
        .i_d (spi_sdi),
        .o_q (w_sdi_s)
    );

    frida_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .i_d (spi_cs_b),
        .o_q (w_cs_s)
    );

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

`ifdef SPI_READBACK_EN
    assign w_preload = r_cfg;
`else
    assign w_preload = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sreg   <= '0;
            r_cfg    <= '0;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            r_update <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // Level test also catches a cs fall that landed in COMMIT
                    if (!w_cs_s) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_sreg  <= w_preload;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= COMMIT;
                    end else if (w_sclk_rise) begin
                        r_sreg <= {r_sreg[CFG_W-2:0], w_sdi_s};
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cfg    <= r_sreg;
                        r_valid  <= 1'b1;
                        r_update <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic r_sdo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdo <= 1'b0;
        end else begin
            r_sdo <= w_cs_s ? 1'b0 : r_sreg[CFG_W-1];
        end
    end

    assign spi_sdo = r_sdo;
`else
    assign spi_sdo = 1'b0;
`endif

    assign cfg_q      = r_cfg;
    assign cfg_valid  = r_valid;
    assign cfg_update = r_update;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_frida_spi_cfg.sv
// Directed and jittered-frame bench for frida_spi_cfg.
// Build option: SPI_READBACK_EN enables the sdo readback expectations.
module tb_frida_spi_cfg;
    import frida_pkg::*;

    localparam int W = CFG_W_DEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         sdi;
    logic         cs_b;
    logic         sdo;
    logic [W-1:0] q;
    logic         valid;
    logic         upd;
    logic         err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_upd  = 0;
    int n_err  = 0;
    int n_both = 0;

    logic [W-1:0] cap;
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_b;
    logic [W-1:0] ones;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_sdo;

    frida_spi_cfg dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (sclk),
        .spi_sdi    (sdi),
        .spi_cs_b   (cs_b),
        .spi_sdo    (sdo),
        .cfg_q      (q),
        .cfg_valid  (valid),
        .cfg_update (upd),
        .frame_err  (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (upd) n_upd++;
            if (err) n_err++;
            if (upd && err) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd_exp(input logic [W-1:0] prev);
`ifdef SPI_READBACK_EN
        return prev;
`else
        return '0;
`endif
    endfunction

    task automatic clk_bits(input logic [W-1:0] d, input int n,
                            input int hmin, input int hvar);
        logic [W-1:0] s;
        s = d;
        for (int i = 0; i < n; i++) begin
            sdi = s[W-1];
            s   = s << 1;
            #(hmin + int'($urandom_range(hvar, 0)));
            sclk = 1'b1;
            cap  = {cap[W-2:0], sdo};
            #(hmin + int'($urandom_range(hvar, 0)));
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [W-1:0] d, input int n,
                         input int hmin, input int hvar);
        cap  = '0;
        cs_b = 1'b0;
        repeat (8) @(posedge clk);
        #(int'($urandom_range(hvar, 0)));
        clk_bits(d, n, hmin, hvar);
        #(hmin);
        cs_b = 1'b1;
        sdi  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [183:0] t;
        logic [191:0] r;
        int u0;
        int e0;
        int len;

        t     = {23{8'hA5}};
        pat_a = t[W-1:0];
        t     = {46{4'h3}};
        pat_b = t[W-1:0] ^ {W{1'b1}} << 7;
        ones  = '1;

        rst  = 1'b1;
        sclk = 1'b0;
        sdi  = 1'b0;
        cs_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_q", q, '0);
        chk("rst_valid", W'(valid), '0);
        chk("rst_upd", W'(upd), '0);
        chk("rst_err", W'(err), '0);
        chk("rst_sdo", W'(sdo), '0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        cs_b = 1'b0;
        repeat (10) @(posedge clk);
        cs_b = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("zero_err", W'(n_err), W'(1));
        chk("zero_upd", W'(n_upd), '0);
        chk("zero_valid", W'(valid), '0);
        chk("zero_q", q, '0);

        frame(pat_a, W, 50, 0);
        chk("full_q", q, pat_a);
        chk("full_upd", W'(n_upd), W'(1));
        chk("full_valid", W'(valid), W'(1));
        chk("full_err", W'(n_err), W'(1));
        chk("full_sdo", cap, rd_exp('0));

        frame(pat_b, W - 1, 50, 0);
        chk("short_err", W'(n_err), W'(2));
        chk("short_q", q, pat_a);
        chk("short_upd", W'(n_upd), W'(1));

        frame(pat_b, W + 1, 50, 0);
        chk("long_err", W'(n_err), W'(3));
        chk("long_q", q, pat_a);
        chk("long_upd", W'(n_upd), W'(1));

        frame(pat_b, W, 50, 0);
        chk("rb_q", q, pat_b);
        chk("rb_sdo", cap, rd_exp(pat_a));
        chk("rb_upd", W'(n_upd), W'(2));

        u0 = n_upd;
        e0 = n_err;
        cs_b = 1'b0;
        repeat (8) @(posedge clk);
        clk_bits(pat_a, 90, 50, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_q", q, '0);
        chk("mid_rst_valid", W'(valid), '0);
        chk("mid_rst_sdo", W'(sdo), '0);
        cs_b = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_pulse", W'(n_upd - u0 + n_err - e0), '0);
        frame(ones, W, 50, 0);
        chk("ones_q", q, ones);
        chk("ones_err", W'(n_err - e0), '0);
        chk("ones_upd", W'(n_upd - u0), W'(1));
        chk("ones_sdo", cap, rd_exp('0));

        exp_q = ones;
        for (int f = 0; f < 25; f++) begin
            r = {$urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom};
            case ($urandom_range(3, 0))
                0:       len = W - 1;
                1:       len = W + 1;
                default: len = W;
            endcase
            u0 = n_upd;
            e0 = n_err;
            exp_sdo = rd_exp(exp_q);
            frame(r[W-1:0], len, 40, 15);
            if (len == W) begin
                exp_q = r[W-1:0];
                chk("rnd_sdo", cap, exp_sdo);
            end
            chk("rnd_q", q, exp_q);
            chk("rnd_upd", W'(n_upd - u0), W'(len == W));
            chk("rnd_err", W'(n_err - e0), W'(len != W));
        end

        chk("never_both", W'(n_both), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
